// File: rtl/special_reg_bank.sv
// special_reg_bank
// Seven WIDTH-bit special-purpose counters (ROW, COL, CURR, STA, STB, STC, R1)
// advanced by one-bit increment strobes, with a datapath write port, a
// registered read port and sticky per-register overflow flags.
// Register index map: 0=ROW 1=COL 2=CURR 3=STA 4=STB 5=STC 6=R1, 7 unmapped.
// Build option: define SRB_SATURATE_EN to make counters hold at all-ones
// instead of wrapping to zero (overflow flag is still raised).

module special_reg_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_ROW,
    input  logic             inc_COL,
    input  logic             inc_CURR,
    input  logic             inc_STA,
    input  logic             inc_STB,
    input  logic             inc_STC,
    input  logic             inc_R1,
    input  logic             wr_en,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] row_q,
    output logic [WIDTH-1:0] col_q,
    output logic [WIDTH-1:0] curr_q,
    output logic [WIDTH-1:0] sta_q,
    output logic [WIDTH-1:0] stb_q,
    output logic [WIDTH-1:0] stc_q,
    output logic [WIDTH-1:0] r1_q,
    output logic [6:0]       ovf,
    input  logic             ovf_clr
);

    localparam int NREG = 7;

    logic [WIDTH-1:0] regs     [NREG];
    logic [WIDTH-1:0] regs_nxt [NREG];
    logic [NREG-1:0]  ovf_q;
    logic [NREG-1:0]  ovf_nxt;
    logic [NREG-1:0]  inc_vec;
    logic [WIDTH-1:0] rd_nxt;

    assign inc_vec = {inc_R1, inc_STC, inc_STB, inc_STA, inc_CURR, inc_COL, inc_ROW};

    // Per-register next value: write beats increment beats hold.
    // A new overflow beats ovf_clr; a write always clears its own flag.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_nxt[i] = regs[i];
            ovf_nxt[i]  = ovf_q[i] & ~ovf_clr;
            if (wr_en && (wr_sel == 3'(i))) begin
                regs_nxt[i] = wr_data;
                ovf_nxt[i]  = 1'b0;
            end else if (inc_vec[i]) begin
                if (&regs[i]) begin
                    ovf_nxt[i] = 1'b1;
`ifdef SRB_SATURATE_EN
                    regs_nxt[i] = regs[i];
`else
                    regs_nxt[i] = '0;
`endif
                end else begin
                    regs_nxt[i] = regs[i] + WIDTH'(1);
                end
            end
        end
    end

    // Read mux sees pre-update contents, so same-cycle writes are not bypassed.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_nxt = regs[i];
            end
        end
    end

    // Register state, overflow flags and read data, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            ovf_q   <= '0;
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= regs_nxt[i];
            end
            ovf_q   <= ovf_nxt;
            rd_data <= rd_nxt;
        end
    end

    assign row_q  = regs[0];
    assign col_q  = regs[1];
    assign curr_q = regs[2];
    assign sta_q  = regs[3];
    assign stb_q  = regs[4];
    assign stc_q  = regs[5];
    assign r1_q   = regs[6];
    assign ovf    = ovf_q;

endmodule
